oled_spi_sniffer: RTL and testbench
===================================

Name: oled_spi_sniffer

Overview:
- Receive-side counterpart of the PMOD OLED SPI driver.
- Passively monitors the 4-wire SSD1331 SPI bus (cs, sclk, sdin, d_cn) on the system clock.
- Rebuilds command and data bytes, then assembles RGB565 pixels with a running pixel index.
- Used on the interconnect/pmod loopback to debug the OLED path; results drive LEDs or a logic-capture block.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on all four bus inputs (minimum 2).
- OLED_W, 96, pixels per row.
- OLED_H, 64, rows per frame.
- ERR_W, 8, width of the framing-error counter.

Ports:
- clk  in  1  system clock; must be ≥ 4× the sclk frequency.
- reset_n  in  1  asynchronous active-low reset.
- spi_cs  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, mode 0.
- spi_sdin  in  1  serial data, MSB first.
- spi_dc  in  1  d_cn line: 0 = command, 1 = data.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  received byte; held until the next byte.
- byte_is_data  out  1  spi_dc value captured with bit 7 of the byte.
- pixel_valid  out  1  one-cycle pulse per assembled pixel.
- pixel_data  out  16  RGB565 pixel, high byte first on the wire.
- pixel_index  out  13  index of the pixel on pixel_data.
- frame_done  out  1  one-cycle pulse with the last pixel of a frame.
- err_cnt  out  ERR_W  saturating count of aborted bytes.
- busy  out  1  high while cs is low (synchronised).

Behaviour:
- Reset: all outputs 0. Shift register, bit count and pixel phase are cleared. pixel_index is 0.
- Synchronisers: all four inputs pass through SYNC_STAGES flops. sclk rise = sync sclk is 1 now and was 0 last cycle.
- State machine:
  - IDLE: wait for sync cs = 0, then go to SHIFT with bit count 0.
  - SHIFT: on each sclk rise, shift in sdin (MSB first) and increment the bit count.
  - On the 8th rise, also capture dc and go to EMIT.
  - EMIT: lasts exactly one cycle. Pulse byte_valid, update byte_data and byte_is_data, then return to SHIFT (cs still low) or IDLE.
- Latency: byte_valid fires SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pins.
- cs rising with bit count 1–7: discard the partial byte, increment err_cnt (saturate at all-ones), go to IDLE. No byte_valid.
- cs rising with bit count 0: not an error.
- Back-to-back bytes with no cs gap are legal.
- Pixel assembly, data bytes (is_data = 1):
  - Phase 0: store as the high byte, set phase to 1.
  - Phase 1: form the pixel from {high, this byte}, pulse pixel_valid in the same cycle as byte_valid, set phase to 0.
  - pixel_index shows the current pixel during pixel_valid and increments afterwards.
  - Wrap: at OLED_W*OLED_H−1 (6143 with defaults), pulse frame_done with pixel_valid, and the next index is 0.
- Command bytes (is_data = 0):
  - Any command byte clears the pixel phase; a pending high byte is dropped with no error.
  - Command 0x15 (set column address) or 0x75 (set row address) also resets pixel_index to 0.
- Error interaction: a discarded partial byte does not change the pixel phase.
- busy: equals the inverted synchronised cs.
- Reset mid-byte or mid-pixel: everything clears immediately (asynchronously), and no pulses are emitted.

Optional Feature:
- Macro: OLED_SNIFF_PIXEL_EN.
- Defined: pixel assembly, pixel_index and frame_done are built as described above.
- Not defined: pixel_valid, pixel_data, pixel_index and frame_done are tied to 0, and no pixel logic is synthesised. Byte outputs, err_cnt and busy are unchanged.

Test Plan:
- Command byte: cs low, dc = 0, send 0xAE at sclk = clk/8, cs high → one byte_valid with byte_data = 0xAE and byte_is_data = 0; err_cnt = 0; no pixel_valid.
- Data bytes: dc = 1, send 0xF8, 0x1F back-to-back in one cs window → two byte_valid pulses; pixel_valid with pixel_data = 0xF81F and pixel_index = 0; the next pixel gets index 1.
- Aborted byte: raise cs after 5 bits → no byte_valid, err_cnt = 1. Repeat 300 times with ERR_W = 8 → err_cnt saturates at 255.
- Full frame: stream 6144 pixels (12288 data bytes) → frame_done pulses exactly once, with pixel_index = 6143; the next pixel has index 0.
- Command mid-pixel: send data 0x12, then command 0x15, then data 0x34, 0x56 → the 0x12 is dropped, pixel 0x3456 appears at index 0.
- Reset and macro build: assert reset_n low after 3 bits → all outputs 0 and the next full byte decodes correctly. Build without OLED_SNIFF_PIXEL_EN → pixel_valid stays 0 while the byte outputs still match the first scenario.

Source files
------------

// File: rtl/oled_spi_sniffer.sv
// Passive SSD1331 4-wire SPI monitor: rebuilds bytes and, with OLED_SNIFF_PIXEL_EN
// defined, RGB565 pixels with a running pixel index and frame-done pulse.
module oled_spi_sniffer #(
   parameter int SYNC_STAGES = 2,
   parameter int OLED_W      = 96,
   parameter int OLED_H      = 64,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spi_cs,
   input  logic             spi_sclk,
   input  logic             spi_sdin,
   input  logic             spi_dc,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   output logic             byte_is_data,
   output logic             pixel_valid,
   output logic [15:0]      pixel_data,
   output logic [12:0]      pixel_index,
   output logic             frame_done,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy
);

   localparam logic [12:0] PIX_LAST = 13'(OLED_W * OLED_H - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, EMIT} state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdin_sync_q, dc_sync_q;
   logic                   sclk_prev_q;
   logic                   cs_s, sclk_s, sdin_s, dc_s, sclk_rise;

   state_t                 state_q;
   logic [7:0]             shift_q;
   logic [2:0]             bitcnt_q;
   logic                   dc_q;
   logic                   byte_valid_q, byte_is_data_q;
   logic [7:0]             byte_data_q;
   logic [ERR_W-1:0]       err_q;

   // cs synchroniser resets high so busy reads 0 while in reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         sdin_sync_q <= '0;
         dc_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], spi_sdin};
         dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
         sclk_prev_q <= sclk_s;
      end
   end

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
   assign dc_s      = dc_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         shift_q        <= '0;
         bitcnt_q       <= '0;
         dc_q           <= 1'b0;
         byte_valid_q   <= 1'b0;
         byte_data_q    <= '0;
         byte_is_data_q <= 1'b0;
         err_q          <= '0;
      end else begin
         byte_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               bitcnt_q <= '0;
               if (!cs_s) state_q <= SHIFT;
            end
            SHIFT: begin
               if (cs_s) begin
                  // a partial byte at deselect counts as a framing error
                  if (bitcnt_q != 3'd0 && err_q != '1) err_q <= err_q + 1'b1;
                  bitcnt_q <= '0;
                  state_q  <= IDLE;
               end else if (sclk_rise) begin
                  shift_q  <= {shift_q[6:0], sdin_s};
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     dc_q    <= dc_s;
                     state_q <= EMIT;
                  end
               end
            end
            EMIT: begin
               byte_valid_q   <= 1'b1;
               byte_data_q    <= shift_q;
               byte_is_data_q <= dc_q;
               state_q        <= cs_s ? IDLE : SHIFT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign byte_valid   = byte_valid_q;
   assign byte_data    = byte_data_q;
   assign byte_is_data = byte_is_data_q;
   assign err_cnt      = err_q;
   assign busy         = ~cs_s;

`ifdef OLED_SNIFF_PIXEL_EN
   logic        phase_q, pixel_valid_q, frame_done_q;
   logic [7:0]  hi_q;
   logic [15:0] pixel_data_q;
   logic [12:0] pixel_index_q, idx_q;

   // EMIT is the cycle before byte_valid, so pixel pulses line up with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q       <= 1'b0;
         hi_q          <= '0;
         pixel_valid_q <= 1'b0;
         pixel_data_q  <= '0;
         pixel_index_q <= '0;
         idx_q         <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         if (state_q == EMIT) begin
            if (dc_q) begin
               if (!phase_q) begin
                  hi_q    <= shift_q;
                  phase_q <= 1'b1;
               end else begin
                  phase_q       <= 1'b0;
                  pixel_valid_q <= 1'b1;
                  pixel_data_q  <= {hi_q, shift_q};
                  pixel_index_q <= idx_q;
                  frame_done_q  <= (idx_q == PIX_LAST);
                  idx_q         <= (idx_q == PIX_LAST) ? 13'd0 : idx_q + 13'd1;
               end
            end else begin
               phase_q <= 1'b0;
               if (shift_q == 8'h15 || shift_q == 8'h75) idx_q <= '0;
            end
         end
      end
   end

   assign pixel_valid = pixel_valid_q;
   assign pixel_data  = pixel_data_q;
   assign pixel_index = pixel_index_q;
   assign frame_done  = frame_done_q;
`else
   logic unused_cfg;
   assign unused_cfg  = ^PIX_LAST;
   assign pixel_valid = 1'b0;
   assign pixel_data  = '0;
   assign pixel_index = '0;
   assign frame_done  = 1'b0;
`endif

endmodule

// File: tb/tb_oled_spi_sniffer.sv
// Directed bench for oled_spi_sniffer; pixel checks run when OLED_SNIFF_PIXEL_EN is defined.
module tb_oled_spi_sniffer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_cs = 1'b1, spi_sclk = 1'b0, spi_sdin = 1'b0, spi_dc = 1'b0;
   logic        byte_valid, byte_is_data, pixel_valid, frame_done, busy;
   logic [7:0]  byte_data, err_cnt;
   logic [15:0] pixel_data;
   logic [12:0] pixel_index;

   int total = 0, bad = 0;
   int cyc = 0, rise_cyc = 0;
   int bv_cnt = 0, pv_cnt = 0, fd_cnt = 0, bv_lat = 0;
   logic [7:0]  bv_byte = '0;
   logic        bv_isd = 1'b0, fd_with_pv = 1'b0;
   logic [15:0] pv_data = '0;
   logic [12:0] pv_idx = '0, fd_idx = '0;

   // 4x2 frame keeps the full-frame wrap test short
   oled_spi_sniffer #(.SYNC_STAGES(2), .OLED_W(4), .OLED_H(2), .ERR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
      .spi_sdin(spi_sdin), .spi_dc(spi_dc), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_is_data(byte_is_data), .pixel_valid(pixel_valid),
      .pixel_data(pixel_data), .pixel_index(pixel_index), .frame_done(frame_done),
      .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (byte_valid) begin
         bv_cnt++;
         bv_byte = byte_data;
         bv_isd  = byte_is_data;
         bv_lat  = cyc - rise_cyc;
      end
      if (pixel_valid) begin
         pv_cnt++;
         pv_data = pixel_data;
         pv_idx  = pixel_index;
      end
      if (frame_done) begin
         fd_cnt++;
         fd_idx     = pixel_index;
         fd_with_pv = pixel_valid;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: timeout expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
      for (int i = 7; i > 7 - n; i--) begin
         spi_sdin = b[i];
         spi_dc   = dc;
         tick(4);
         spi_sclk = 1'b1;
         if (i == 0) rise_cyc = cyc;
         tick(4);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      send_bits(b, 8, dc);
   endtask

   task automatic cs_open();
      spi_cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_close();
      tick(4);
      spi_cs = 1'b1;
      tick(8);
   endtask

   task automatic abort5();
      cs_open();
      send_bits(8'hA5, 5, 1'b1);
      cs_close();
   endtask

   initial begin
      int b0;
      tick(3);
      chk("reset_outputs", {byte_valid, byte_data, byte_is_data, pixel_valid, pixel_data,
                            pixel_index, frame_done, err_cnt, busy}, 64'd0);
      reset_n = 1'b1;
      tick(4);

      // command byte 0xAE
      cs_open();
      chk("busy_low_cs", busy, 1);
      send_byte(8'hAE, 1'b0);
      cs_close();
      chk("cmd_latency", bv_lat, 4);
      chk("cmd_count", bv_cnt, 1);
      chk("cmd_byte", bv_byte, 8'hAE);
      chk("cmd_isdata", bv_isd, 0);
      chk("cmd_err", err_cnt, 0);
      chk("cmd_nopix", pv_cnt, 0);
      chk("busy_idle", busy, 0);

      // back-to-back data bytes forming one pixel, then a second pixel
      cs_open();
      send_byte(8'hF8, 1'b1);
      send_byte(8'h1F, 1'b1);
      cs_close();
      chk("data_count", bv_cnt, 3);
      chk("data_byte", bv_byte, 8'h1F);
      chk("data_isdata", bv_isd, 1);
      cs_open();
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      cs_close();
`ifdef OLED_SNIFF_PIXEL_EN
      chk("pix_count", pv_cnt, 2);
      chk("pix2_data", pv_data, 16'h0001);
      chk("pix2_index", pv_idx, 1);
`else
      chk("nopix_count", pv_cnt, 0);
`endif

      // command mid-pixel drops the high byte and 0x15 resets the index
      cs_open();
      send_byte(8'h12, 1'b1);
      send_byte(8'h15, 1'b0);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      cs_close();
      chk("mid_count", bv_cnt, 9);
      chk("mid_byte", bv_byte, 8'h56);
`ifdef OLED_SNIFF_PIXEL_EN
      chk("mid_pix_count", pv_cnt, 3);
      chk("mid_pix_data", pv_data, 16'h3456);
      chk("mid_pix_index", pv_idx, 0);

      // full 8-pixel frame after 0x75 resets the index
      cs_open();
      send_byte(8'h75, 1'b0);
      for (int k = 0; k < 8; k++) begin
         send_byte(8'(k), 1'b1);
         send_byte(8'hA0 + 8'(k), 1'b1);
      end
      cs_close();
      chk("frame_pix_count", pv_cnt, 11);
      chk("frame_done_count", fd_cnt, 1);
      chk("frame_done_index", fd_idx, 7);
      chk("frame_done_with_pv", fd_with_pv, 1);
      chk("frame_last_data", pv_data, 16'h07A7);
      cs_open();
      send_byte(8'hBE, 1'b1);
      send_byte(8'hEF, 1'b1);
      cs_close();
      chk("wrap_index", pv_idx, 0);
      chk("wrap_data", pv_data, 16'hBEEF);
      chk("wrap_fd_count", fd_cnt, 1);
`endif

      // aborted byte leaves pixel phase intact
      cs_open();
      send_byte(8'hAB, 1'b1);
      cs_close();
      b0 = bv_cnt;
      abort5();
      chk("abort_nobyte", bv_cnt, b0);
      chk("abort_err", err_cnt, 1);
      cs_open();
      cs_close();
      chk("empty_window_err", err_cnt, 1);
      cs_open();
      send_byte(8'hCD, 1'b1);
      cs_close();
      chk("after_abort_byte", bv_byte, 8'hCD);
`ifdef OLED_SNIFF_PIXEL_EN
      chk("abort_keeps_phase", pv_data, 16'hABCD);
`endif
      for (int k = 0; k < 299; k++) abort5();
      chk("err_saturate", err_cnt, 8'hFF);

      // asynchronous reset after 3 bits
      cs_open();
      send_bits(8'hFF, 3, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midbyte_reset_outputs", {byte_valid, byte_data, byte_is_data, pixel_valid, pixel_data,
                                    pixel_index, frame_done, err_cnt, busy}, 64'd0);
      spi_cs = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(4);
      b0 = bv_cnt;
      cs_open();
      send_byte(8'h5A, 1'b0);
      cs_close();
      chk("post_reset_count", bv_cnt, b0 + 1);
      chk("post_reset_byte", bv_byte, 8'h5A);
      chk("post_reset_isdata", bv_isd, 0);
      chk("post_reset_err", err_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
